// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage data-cache controller.
//   mem_state_t        : controller FSM states
//   DEF_IDX_BITS       : default cache index width
//   lane_extract_sext  : pick one byte lane of a word and sign-extend it
//   lane_merge         : merge the masked byte lanes of a new word into an old word
//   lane_mask          : byte-enable mask for a word or single-byte access
package mem_pkg;

    localparam int unsigned DEF_IDX_BITS = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } mem_state_t;

    function automatic logic [31:0] lane_extract_sext(input logic [31:0] word,
                                                      input logic [1:0]  lane);
        logic [7:0] b;
        b = word[8*lane +: 8];
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  mask);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [3:0] lane_mask(input logic       is_word,
                                             input logic [1:0] lane);
        return is_word ? 4'hF : 4'(4'b0001 << lane);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped line storage: valid/dirty/tag/data per one-word line.
//   clk, rst_n          : clock, async active-low reset (clears valid and dirty only)
//   rd_idx              : combinational read index
//   rd_*_c              : combinational read data of line rd_idx
//   wr_en, wr_idx       : synchronous write strobe and index
//   wr_valid, wr_dirty  : new valid/dirty bits
//   wr_tag              : new tag
//   wr_data, wr_mask    : new data and byte-lane write mask
module dcache_array
    import mem_pkg::*;
#(
    parameter  int unsigned IDX_BITS = DEF_IDX_BITS,
    localparam int unsigned TAG_BITS = 32 - IDX_BITS - 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_valid_c,
    output logic                rd_dirty_c,
    output logic [TAG_BITS-1:0] rd_tag_c,
    output logic [31:0]         rd_data_c,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_valid,
    input  logic                wr_dirty,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic [31:0]         wr_data,
    input  logic [3:0]          wr_mask
);

    localparam int unsigned LINES = 1 << IDX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    // Status bits are reset; tag/data are qualified by valid and left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_valid;
            dirty_q[wr_idx] <= wr_dirty;
        end
    end

    // Tag and byte-masked data write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= lane_merge(data_q[wr_idx], wr_data, wr_mask);
        end
    end

    assign rd_valid_c = valid_q[rd_idx];
    assign rd_dirty_c = dirty_q[rd_idx];
    assign rd_tag_c   = tag_q[rd_idx];
    assign rd_data_c  = data_q[rd_idx];

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: write-back/write-allocate direct-mapped data cache
// with a writeback/fill handshake to main memory.
//   clk, rst_n            : clock, async active-low reset
//   valid_in, mem_read_in, mem_write_in, is_word_in, addr_in, store_data_in
//                         : access from EX (held stable while mem_stall)
//   load_data, mem_stall  : combinational load result and pipeline stall
//   mem_req, mem_we, mem_addr, mem_wdata : registered memory request
//   mem_ack, mem_rdata    : memory completion pulse and fill data
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned IDX_BITS = DEF_IDX_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        is_word_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic [31:0] load_data,
    output logic        mem_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned TAG_BITS = 32 - IDX_BITS - 2;

    mem_state_t          state;
    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic [1:0]          lane;
    logic                access;
    logic                hit_idle;
    logic                fill_done;

    logic                rd_valid;
    logic                rd_dirty;
    logic [TAG_BITS-1:0] rd_tag;
    logic [31:0]         rd_data;

    logic                wr_en;
    logic                wr_dirty;
    logic [31:0]         wr_data;
    logic [3:0]          wr_mask;

    assign idx  = addr_in[IDX_BITS+1:2];
    assign tag  = addr_in[31:IDX_BITS+2];
    assign lane = addr_in[1:0];

    assign access    = valid_in & (mem_read_in | mem_write_in);
    assign hit_idle  = access & rd_valid & (rd_tag == tag) & (state == IDLE);
    assign fill_done = (state == FILL) & mem_ack;

    // Zero-latency hit path; a miss stalls from the detecting cycle until the refilled line hits.
    assign mem_stall = rst_n & access & ~hit_idle;
    assign load_data = (rst_n & hit_idle & mem_read_in)
                     ? (is_word_in ? rd_data : lane_extract_sext(rd_data, lane))
                     : '0;

    // Array write: fill completion has priority; otherwise a store hit.
    always_comb begin
        wr_en    = 1'b0;
        wr_dirty = 1'b0;
        wr_data  = mem_rdata;
        wr_mask  = 4'hF;
        if (fill_done) begin
            wr_en = 1'b1;
        end else if (hit_idle && mem_write_in) begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
            wr_data  = is_word_in ? store_data_in : {4{store_data_in[7:0]}};
            wr_mask  = lane_mask(is_word_in, lane);
        end
    end

    dcache_array #(
        .IDX_BITS (IDX_BITS)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx     (idx),
        .rd_valid_c (rd_valid),
        .rd_dirty_c (rd_dirty),
        .rd_tag_c   (rd_tag),
        .rd_data_c  (rd_data),
        .wr_en      (wr_en),
        .wr_idx     (idx),
        .wr_valid   (1'b1),
        .wr_dirty   (wr_dirty),
        .wr_tag     (tag),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask)
    );

    // Miss FSM with registered memory request; outputs hold until the ack cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !hit_idle) begin
                        mem_req <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state     <= WRITEBACK;
                            mem_we    <= 1'b1;
                            mem_addr  <= {rd_tag, idx, 2'b00};
                            mem_wdata <= rd_data;
                        end else begin
                            state    <= FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= {tag, idx, 2'b00};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        state    <= FILL;
                        mem_we   <= 1'b0;
                        mem_addr <= {tag, idx, 2'b00};
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule
